mem_rr_scheduler: RTL and testbench
===================================

Name: mem_rr_scheduler

Overview:
Four-channel round-robin scheduler for the shared ROM access path, used by the storage controllers to share the FIFO/ROM middleware. It takes one request line per storage controller and issues a registered one-hot grant. The grant stays locked until the memory side reports transaction completion or a watchdog timeout fires. It also keeps per-channel grant counters and an error record for debug readback.

Parameters:
TIMEOUT, 64, cycles in BUSY without txn_done before the grant is forcibly revoked; legal range 2..255
CNT_W, 8, width of each per-channel grant counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request lines; bit i is storage controller i+1; level-sensitive
txn_done  input  1  single-cycle pulse from the memory middleware: current transaction result is valid
grant  output  4  registered one-hot grant, or 0 when idle
busy  output  1  high while a grant is held (BUSY state)
timeout_err  output  1  single-cycle pulse when a grant is revoked by the watchdog
err_id  output  2  index of the channel that last timed out; holds its value until the next timeout
grant_cnt_flat  output  4*CNT_W  per-channel count of completed grants; channel i is in bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (asynchronous, rst_n=0):
  - grant=0, busy=0, timeout_err=0, err_id=0, all counters=0.
  - Round-robin pointer last=3, so channel 0 has top priority first.
  - State is IDLE.
  - Reset asserted mid-transaction clears grant in the same instant; there is no completion and no counter update.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If req!=0, pick the winner by searching from (last+1) mod 4 upward with wrap.
  - On the next edge: grant=onehot(winner), busy=1, watchdog=0, state goes to BUSY.
  - Latency from req asserted to grant is exactly 1 cycle.
  - If req==0, stay in IDLE with grant=0.
- BUSY:
  - grant is held constant regardless of req. A requester dropping req does not release the grant.
  - The watchdog increments every cycle.
  - txn_done=1 ends the transaction:
    - next edge: grant=0, busy=0, last=winner;
    - grant_cnt[winner]++, saturating at all-ones;
    - state goes to GAP.
  - Watchdog reaching TIMEOUT-1 with txn_done=0 revokes the grant:
    - next edge: grant=0, busy=0, timeout_err=1 for one cycle, err_id=winner, last=winner;
    - no counter increment;
    - state goes to GAP.
  - txn_done and the timeout condition in the same cycle: completion wins and timeout_err is not raised.
  - txn_done while in IDLE or GAP is ignored; it produces no counter change.
- GAP:
  - One mandatory idle cycle with grant=0, so the released controller can deassert req.
  - Then always go to IDLE.
  - Minimum spacing between successive grants is therefore 2 cycles after the done edge.
- Fairness: with all four requests held continuously, grants rotate 0,1,2,3,0,...
- grant is always one-hot or zero; two bits set at once is a design error and is checked by an assertion.
- All outputs are driven from registers; there are no combinational paths from input to output.

Test Plan:
1. Reset, then req=4'b0100 → grant=4'b0100 one cycle later, busy=1. txn_done pulse → grant=0 next cycle, grant_cnt[2]=1. After GAP, with req still 4'b0100, channel 2 is granted again.
2. req=4'b1111 held, with txn_done 3 cycles after each grant → grant sequence 0001, 0010, 0100, 1000, 0001. Each counter equals 1 after the first four grants.
3. TIMEOUT=64, req=4'b0010, txn_done never sent → grant revoked after exactly 64 BUSY cycles. timeout_err pulses once, err_id=1, grant_cnt[1] stays 0. The next grant goes to a higher-index requester if one is pending.
4. txn_done and the timeout condition in the same cycle → grant_cnt increments and timeout_err stays 0. Separately, a txn_done pulse while IDLE → no state or counter change.
5. While granted to channel 3, drop req[3] and assert req[0] → grant stays 4'b1000 until txn_done. Channel 0 is granted 2 cycles after the done edge.
6. Pull rst_n low mid-BUSY → grant=0 and busy=0 immediately (no clock edge needed), counters are cleared, and the first grant after release goes to the lowest requesting index.

Source files
------------

// File: rtl/mem_rr_scheduler.sv
// Four-channel round-robin scheduler for the shared ROM access path.
// Registered one-hot grant held until txn_done or a watchdog timeout; per-channel grant counters.
module mem_rr_scheduler #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic               txn_done,
  output logic [3:0]         grant,
  output logic               busy,
  output logic               timeout_err,
  output logic [1:0]         err_id,
  output logic [4*CNT_W-1:0] grant_cnt_flat
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [3:0]       grant_next;
  logic             busy_next, tout_next;
  logic [1:0]       err_id_next;
  logic [1:0]       last, last_next;
  logic [1:0]       owner, owner_next;
  logic [7:0]       wdog, wdog_next;
  logic [3:0]       cnt_inc;
  logic [CNT_W-1:0] cnt [4];

  // Winner search and all next-state decisions.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next  = state;
    grant_next  = grant;
    busy_next   = busy;
    tout_next   = 1'b0;
    err_id_next = err_id;
    last_next   = last;
    owner_next  = owner;
    wdog_next   = wdog;
    cnt_inc     = '0;

    unique case (state)
      S_IDLE: begin
        if (req != 4'b0000) begin
          for (int k = 4; k >= 1; k--) begin
            // Descending loop: the last assignment is the closest index after last.
            if (req[last + 2'(k)]) owner_next = last + 2'(k);
          end
          grant_next = 4'b0001 << owner_next;
          busy_next  = 1'b1;
          wdog_next  = '0;
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (txn_done) begin
          grant_next = '0;
          busy_next  = 1'b0;
          last_next  = owner;
          cnt_inc    = grant;
          state_next = S_GAP;
        end else if (wdog == WD_LAST) begin
          grant_next  = '0;
          busy_next   = 1'b0;
          tout_next   = 1'b1;
          err_id_next = owner;
          last_next   = owner;
          state_next  = S_GAP;
        end else begin
          wdog_next = wdog + 8'd1;
        end
      end
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_id      <= '0;
      last        <= 2'd3;
      owner       <= '0;
      wdog        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state       <= state_next;
      grant       <= grant_next;
      busy        <= busy_next;
      timeout_err <= tout_next;
      err_id      <= err_id_next;
      last        <= last_next;
      owner       <= owner_next;
      wdog        <= wdog_next;
    end
  end

  // NOTE: the counters are a small register bank readable for debug, so they are reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt_flat = '0;
    for (int i = 0; i < 4; i++) grant_cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
  end

  grant_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Directed self-checking bench for mem_rr_scheduler (TIMEOUT=64, CNT_W=8).
module tb_mem_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic        txn_done;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  err_id;
  logic [31:0] grant_cnt_flat;

  int checks = 0;
  int errors = 0;

  mem_rr_scheduler #(.TIMEOUT(64), .CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .txn_done       (txn_done),
    .grant          (grant),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .err_id         (err_id),
    .grant_cnt_flat (grant_cnt_flat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cnt_of(input int i);
    return grant_cnt_flat[i*8 +: 8];
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rot [5];
    rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;

    rst_n = 1'b0; req = 4'b0000; txn_done = 1'b0;
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tout", 32'(timeout_err), 32'h0);
    check("rst_err_id", 32'(err_id), 32'h0);
    check("rst_cnt", grant_cnt_flat, 32'h0);
    rst_n = 1'b1;

    // 1: single requester, completion, regrant after GAP
    req = 4'b0100;
    tick();
    check("t1_grant", 32'(grant), 32'h4);
    check("t1_busy", 32'(busy), 32'h1);
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    check("t1_release", 32'(grant), 32'h0);
    check("t1_busy_low", 32'(busy), 32'h0);
    check("t1_cnt2", 32'(cnt_of(2)), 32'h1);
    tick();
    check("t1_gap", 32'(grant), 32'h0);
    tick();
    check("t1_regrant", 32'(grant), 32'h4);
    req = 4'b0000;

    // 2: fairness with all requests held
    pulse_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("t2_grant%0d", g), 32'(grant), 32'(rot[g]));
      tick();
      tick();
      txn_done = 1'b1;
      tick();
      txn_done = 1'b0;
      if (g == 3) check("t2_cnts", grant_cnt_flat, 32'h01010101);
      tick();
    end
    req = 4'b0000;
    tick();

    // 3: watchdog revoke after 64 BUSY cycles
    pulse_reset();
    req = 4'b0010;
    tick();
    check("t3_grant", 32'(grant), 32'h2);
    req = 4'b1010;
    for (int c = 0; c < 63; c++) tick();
    check("t3_still_held", 32'(grant), 32'h2);
    check("t3_no_tout_yet", 32'(timeout_err), 32'h0);
    tick();
    check("t3_revoked", 32'(grant), 32'h0);
    check("t3_tout", 32'(timeout_err), 32'h1);
    check("t3_err_id", 32'(err_id), 32'h1);
    check("t3_cnt1", 32'(cnt_of(1)), 32'h0);
    tick();
    check("t3_tout_pulse", 32'(timeout_err), 32'h0);
    tick();
    check("t3_next_higher", 32'(grant), 32'h8);
    req = 4'b0000;
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    tick();
    check("t3_err_id_hold", 32'(err_id), 32'h1);

    // 4: done coincides with timeout; done while idle
    req = 4'b0001;
    tick();
    check("t4_grant", 32'(grant), 32'h1);
    for (int c = 0; c < 63; c++) tick();
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    check("t4_release", 32'(grant), 32'h0);
    check("t4_no_tout", 32'(timeout_err), 32'h0);
    check("t4_cnt0", 32'(cnt_of(0)), 32'h1);
    req = 4'b0000;
    tick();
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    check("t4_idle_done_grant", 32'(grant), 32'h0);
    check("t4_idle_done_busy", 32'(busy), 32'h0);
    check("t4_idle_done_cnt", grant_cnt_flat, 32'h01000001);

    // 5: grant locked while requester drops out
    req = 4'b1000;
    tick();
    check("t5_grant", 32'(grant), 32'h8);
    req = 4'b0001;
    tick();
    check("t5_lock_a", 32'(grant), 32'h8);
    tick();
    check("t5_lock_b", 32'(grant), 32'h8);
    txn_done = 1'b1;
    tick();
    txn_done = 1'b0;
    check("t5_release", 32'(grant), 32'h0);
    check("t5_cnt3", 32'(cnt_of(3)), 32'h2);
    tick();
    check("t5_gap", 32'(grant), 32'h0);
    tick();
    check("t5_ch0", 32'(grant), 32'h1);

    // 6: asynchronous reset mid-BUSY
    rst_n = 1'b0;
    #1;
    check("t6_grant", 32'(grant), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_cnt", grant_cnt_flat, 32'h0);
    req = 4'b0110;
    rst_n = 1'b1;
    tick();
    check("t6_first", 32'(grant), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
